// File: rtl/rstseq_pkg.sv
// Shared state type and default 80 MHz timing constants for the reset sequencer.
package rstseq_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT,
      ST_STAGE,
      ST_HOLD,
      ST_DONE
   } state_t;

   localparam int CLK_80M = 80_000_000;
   localparam int SEC_CYC = CLK_80M;

   // 20 s power-up, 1 us stagger, 10 ms re-sequence, 1 s watchdog
   localparam int DEF_INIT_DELAY    = 20 * SEC_CYC;
   localparam int DEF_STAGE_GAP     = 80;
   localparam int DEF_RESTART_DELAY = SEC_CYC / 100;
   localparam int DEF_WDT_TIMEOUT   = SEC_CYC;

endpackage

// File: rtl/rstseq_timer.sv
// Up-counter with synchronous clear and enable; expire_o pulses on the enabled
// edge at which the count reaches limit_i-1, i.e. the limit_i-th counted edge.
module rstseq_timer
   import rstseq_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q = '0;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/reset_sequencer.sv
// Staggered power-up enable generator with restart and, when RSTSEQ_WATCHDOG_EN
// is defined, a watchdog that re-sequences if kick stops arriving in ST_DONE.
module reset_sequencer
   import rstseq_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int INIT_DELAY    = DEF_INIT_DELAY,
   parameter int STAGE_GAP     = DEF_STAGE_GAP,
   parameter int RESTART_DELAY = DEF_RESTART_DELAY,
   parameter int WDT_TIMEOUT   = DEF_WDT_TIMEOUT,
   parameter int CNT_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              kick,
   output logic [NUM_CH-1:0] en_out,
   output logic              done,
   output logic              wdt_trip
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   state_t            state_q = ST_INIT;
   state_t            state_d;
   logic [NUM_CH-1:0] en_q    = '0;
   logic [NUM_CH-1:0] en_d;
   logic              done_q  = 1'b0;
   logic              done_d;
   logic [IDX_W-1:0]  idx_q   = '0;
   logic [IDX_W-1:0]  idx_d;

   logic              seq_clr;
   logic              seq_en;
   logic              seq_expire;
   logic [CNT_W-1:0]  seq_limit;
   logic              wdt_expire;

   rstseq_timer #(.CNT_W(CNT_W)) u_seq_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (seq_clr),
      .en_i     (seq_en),
      .limit_i  (seq_limit),
      .expire_o (seq_expire)
   );

   always_comb begin
      state_d   = state_q;
      en_d      = en_q;
      done_d    = done_q;
      idx_d     = idx_q;
      seq_clr   = 1'b0;
      seq_en    = 1'b1;
      seq_limit = CNT_W'(INIT_DELAY);

      unique case (state_q)
         ST_INIT, ST_HOLD: begin
            seq_limit = (state_q == ST_INIT) ? CNT_W'(INIT_DELAY) : CNT_W'(RESTART_DELAY);
            if (seq_expire) begin
               en_d[0] = 1'b1;
               idx_d   = IDX_W'(1);
               seq_clr = 1'b1;
               if (NUM_CH == 1) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_STAGE;
               end
            end
         end
         ST_STAGE: begin
            seq_limit = CNT_W'(STAGE_GAP);
            if (seq_expire) begin
               en_d[idx_q] = 1'b1;
               idx_d       = idx_q + IDX_W'(1);
               seq_clr     = 1'b1;
               if (idx_q == IDX_W'(NUM_CH - 1)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end
         end
         ST_DONE: begin
            seq_en  = 1'b0;
            seq_clr = 1'b1;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Restart (manual or watchdog) overrides whatever the sequence was doing
      if (restart || wdt_expire) begin
         state_d = ST_HOLD;
         en_d    = '0;
         done_d  = 1'b0;
         idx_d   = '0;
         seq_clr = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         en_q    <= '0;
         done_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
      end
   end

   assign en_out = en_q;
   assign done   = done_q;

`ifdef RSTSEQ_WATCHDOG_EN
   logic wdt_run;
   logic trip_q = 1'b0;
   logic trip_d;

   // Counts only idle DONE edges; any kick or other state restarts the window
   assign wdt_run = (state_q == ST_DONE) && !kick;

   rstseq_timer #(.CNT_W(CNT_W)) u_wdt_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (!wdt_run),
      .en_i     (wdt_run),
      .limit_i  (CNT_W'(WDT_TIMEOUT)),
      .expire_o (wdt_expire)
   );

   assign trip_d = trip_q | wdt_expire;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trip_q <= 1'b0;
      end else begin
         trip_q <= trip_d;
      end
   end

   assign wdt_trip = trip_q;
`else
   localparam int unused_wdt_timeout = WDT_TIMEOUT;
   logic unused_kick;

   assign unused_kick = kick;
   assign wdt_expire  = 1'b0;
   assign wdt_trip    = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: timeline model checked every cycle plus literal checkpoints.
`timescale 1ns/1ps
module tb_reset_sequencer;

   localparam int N    = 4;
   localparam int INIT = 10;
   localparam int GAP  = 3;
   localparam int RD   = 5;
   localparam int WDT  = 20;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b0;
   logic         restart = 1'b0;
   logic         kick    = 1'b0;
   logic [N-1:0] en_out;
   logic         done;
   logic         wdt_trip;

   int tests = 0;
   int fails = 0;
   int e     = 0;

   reset_sequencer #(
      .NUM_CH        (N),
      .INIT_DELAY    (INIT),
      .STAGE_GAP     (GAP),
      .RESTART_DELAY (RD),
      .WDT_TIMEOUT   (WDT),
      .CNT_W         (32)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .restart  (restart),
      .kick     (kick),
      .en_out   (en_out),
      .done     (done),
      .wdt_trip (wdt_trip)
   );

   always #5 clk = ~clk;

   // Timeline model: a sequence is anchored at edge 'base'; channel k turns on
   // at base + dly + k*GAP. Reset and restart simply move the anchor.
   longint       cyc    = 0;
   longint       base   = 0;
   longint       dly    = INIT;
   longint       wref   = 0;
   bit           trip_m = 1'b0;
   bit           mvalid = 1'b0;
   logic [N-1:0] en_m   = '0;
   logic         done_m = 1'b0;

   always @(posedge clk) begin
      longint td;
      longint ref_t;
      bit     wtrip;
      cyc++;
      td    = base + dly + longint'((N - 1) * GAP);
      wtrip = 1'b0;
      if (!rst_n) begin
         base   = cyc;
         dly    = INIT;
         trip_m = 1'b0;
         wref   = 0;
         mvalid = 1'b1;
      end else begin
`ifdef RSTSEQ_WATCHDOG_EN
         if (mvalid && cyc > td) begin
            ref_t = (wref > td) ? wref : td;
            if (kick) wref = cyc;
            else if (cyc - ref_t == WDT) wtrip = 1'b1;
         end
`else
         ref_t = 0;
`endif
         if (restart || wtrip) begin
            base = cyc;
            dly  = RD;
         end
         if (wtrip) trip_m = 1'b1;
      end
      for (int k = 0; k < N; k++) en_m[k] = (cyc >= base + dly + longint'(k * GAP));
      done_m = &en_m;
   end

   always @(negedge clk) begin
      if (mvalid) begin
         tests++;
         if (en_out !== en_m || done !== done_m || wdt_trip !== trip_m) begin
            fails++;
            $display("FAIL model cyc=%0d got en=%b done=%b trip=%b exp en=%b done=%b trip=%b",
                     cyc, en_out, done, wdt_trip, en_m, done_m, trip_m);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic run_to(input int t);
      while (e < t) tick();
   endtask

   task automatic chk(input string name, input logic [N-1:0] xe, input logic xd, input logic xt);
      tests++;
      if (en_out !== xe || done !== xd || wdt_trip !== xt) begin
         fails++;
         $display("FAIL %s e=%0d got en=%b done=%b trip=%b exp en=%b done=%b trip=%b",
                  name, e, en_out, done, wdt_trip, xe, xd, xt);
      end else begin
         $display("[TB] ok %s e=%0d en=%b done=%b trip=%b", name, e, en_out, done, wdt_trip);
      end
   endtask

   initial begin
      // Power-up sequence
      repeat (3) tick();
      chk("reset_vals", 4'b0000, 1'b0, 1'b0);
      rst_n = 1'b1; e = 0;
      run_to(9);  chk("pwr_e9",  4'b0000, 1'b0, 1'b0);
      run_to(10); chk("pwr_e10", 4'b0001, 1'b0, 1'b0);
      run_to(13); chk("pwr_e13", 4'b0011, 1'b0, 1'b0);
      run_to(16); chk("pwr_e16", 4'b0111, 1'b0, 1'b0);
      run_to(18); chk("pwr_e18", 4'b0111, 1'b0, 1'b0);
      run_to(19); chk("pwr_e19", 4'b1111, 1'b1, 1'b0);

      // Restart after done
      run_to(24); restart = 1'b1; tick(); restart = 1'b0;
      chk("rs_e25", 4'b0000, 1'b0, 1'b0);
      run_to(29); chk("rs_e29", 4'b0000, 1'b0, 1'b0);
      run_to(30); chk("rs_e30", 4'b0001, 1'b0, 1'b0);
      run_to(38); chk("rs_e38", 4'b0111, 1'b0, 1'b0);
      run_to(39); chk("rs_e39", 4'b1111, 1'b1, 1'b0);

      // Reset mid-stage
      rst_n = 1'b0; tick(); rst_n = 1'b1; e = 0;
      run_to(13); chk("mid_e13", 4'b0011, 1'b0, 1'b0);
      rst_n = 1'b0; tick();
      chk("mid_rst", 4'b0000, 1'b0, 1'b0);
      rst_n = 1'b1; e = 0;
      run_to(9);  chk("mid_e9",  4'b0000, 1'b0, 1'b0);
      run_to(10); chk("mid_e10", 4'b0001, 1'b0, 1'b0);

      // Restart during INIT, then restart held high
      rst_n = 1'b0; tick(); rst_n = 1'b1; e = 0;
      run_to(3); restart = 1'b1; tick(); restart = 1'b0;
      run_to(8);  chk("ri_e8",  4'b0000, 1'b0, 1'b0);
      run_to(9);  chk("ri_e9",  4'b0001, 1'b0, 1'b0);
      run_to(18); chk("ri_e18", 4'b1111, 1'b1, 1'b0);
      run_to(19); restart = 1'b1; repeat (6) tick(); restart = 1'b0;
      chk("hold_e25", 4'b0000, 1'b0, 1'b0);
      run_to(29); chk("hold_e29", 4'b0000, 1'b0, 1'b0);
      run_to(30); chk("hold_e30", 4'b0001, 1'b0, 1'b0);

      // rst_n beats restart
      restart = 1'b1; rst_n = 1'b0; tick();
      chk("prio_rst", 4'b0000, 1'b0, 1'b0);
      restart = 1'b0; rst_n = 1'b1; e = 0;
      run_to(9);  chk("prio_e9",  4'b0000, 1'b0, 1'b0);
      run_to(10); chk("prio_e10", 4'b0001, 1'b0, 1'b0);
      run_to(19); chk("prio_e19", 4'b1111, 1'b1, 1'b0);

`ifdef RSTSEQ_WATCHDOG_EN
      // No kick: trip 20 edges after done
      run_to(38); chk("wdt_e38", 4'b1111, 1'b1, 1'b0);
      run_to(39); chk("wdt_e39", 4'b0000, 1'b0, 1'b1);
      run_to(43); chk("wdt_e43", 4'b0000, 1'b0, 1'b1);
      run_to(44); chk("wdt_e44", 4'b0001, 1'b0, 1'b1);
      restart = 1'b1; tick(); restart = 1'b0;
      chk("wdt_sticky", 4'b0000, 1'b0, 1'b1);
      rst_n = 1'b0; tick();
      chk("wdt_clr", 4'b0000, 1'b0, 1'b0);
      rst_n = 1'b1; e = 0;
      // Kick every 10 edges: never trips
      run_to(19);
      while (e < 80) begin
         kick = ((e + 1) % 10 == 5);
         tick();
      end
      kick = 1'b0;
      chk("wdt_kicked", 4'b1111, 1'b1, 1'b0);
`else
      run_to(60); chk("nowdt_e60", 4'b1111, 1'b1, 1'b0);
`endif

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
